// File: rtl/fx2_pkg.sv
// Shared types and constants for the FX2 slave-FIFO arbiter: FSM encoding,
// FIFOADR values and the last-served side used by the round-robin grant.
package fx2_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_READ   = 3'd2,
    S_WRITE  = 3'd3,
    S_PKTEND = 3'd4
  } fx2_state_e;

  typedef enum logic {
    SIDE_OUT = 1'b0,
    SIDE_IN  = 1'b1
  } fx2_side_e;

  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP6_ADDR = 2'b10;

  function automatic logic [1:0] side_faddr(input fx2_side_e side);
    logic [1:0] addr;
    case (side)
      SIDE_IN:  addr = EP6_ADDR;
      SIDE_OUT: addr = EP2_ADDR;
      default:  addr = EP2_ADDR;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/fx2_pkt_tracker.sv
// Tracks words in the open EP6 IN packet and idle time, and flags when a
// partial packet has sat idle long enough to be committed with PKTEND.
module fx2_pkt_tracker
  import fx2_pkg::*;
#(
  parameter int PKT_WORDS      = 256,
  parameter int PKTEND_TIMEOUT = 64
) (
  input  logic fx2_ifclk,
  input  logic reset_n,
  input  logic wr_beat,
  input  logic pktend_done,
  input  logic idle,
  output logic dirty,
  output logic timeout
);

  localparam int PKT_W  = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int IDLE_W = (PKTEND_TIMEOUT > 1) ? $clog2(PKTEND_TIMEOUT) : 1;
  localparam logic [PKT_W-1:0]  PKT_LAST  = PKT_W'(PKT_WORDS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(PKTEND_TIMEOUT - 1);

  logic [PKT_W-1:0]  pkt_cnt_r;
  logic [IDLE_W-1:0] idle_cnt_r;

  // IN word count; wrapping to zero means the FX2 auto-committed the packet.
  always_ff @(posedge fx2_ifclk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_r <= '0;
    end else if (pktend_done) begin
      pkt_cnt_r <= '0;
    end else if (wr_beat) begin
      pkt_cnt_r <= (pkt_cnt_r == PKT_LAST) ? '0 : pkt_cnt_r + 1'b1;
    end
  end

  // Saturating idle counter, restarted by any IN beat or commit.
  always_ff @(posedge fx2_ifclk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_r <= '0;
    end else if (wr_beat || pktend_done) begin
      idle_cnt_r <= '0;
    end else if (idle && (idle_cnt_r != IDLE_LAST)) begin
      idle_cnt_r <= idle_cnt_r + 1'b1;
    end
  end

  assign dirty   = (pkt_cnt_r != '0);
  assign timeout = dirty && (idle_cnt_r == IDLE_LAST);

endmodule

// File: rtl/fx2_slavefifo_arb.sv
// FX2 slave-FIFO controller: round-robin bursts between EP2 OUT -> tx FIFO and
// rx FIFO -> EP6 IN, with idle-timeout PKTEND. Define FX2_ARB_STATS_EN for counters.
module fx2_slavefifo_arb
  import fx2_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int BURST_MAX      = 256,
  parameter int PKT_WORDS      = 256,
  parameter int PKTEND_TIMEOUT = 64,
  parameter int ADDR_SETUP     = 2,
  parameter int STARTUP_CYC    = 8
) (
  input  logic              fx2_ifclk,
  input  logic              reset_n,
  input  logic              fx2_flagb,
  input  logic              fx2_flagc,
  input  logic [DATA_W-1:0] fx2_fd_i,
  output logic [DATA_W-1:0] fx2_fd_o,
  output logic              fx2_fd_oe,
  output logic [1:0]        fx2_faddr,
  output logic              fx2_sloe,
  output logic              fx2_slrd,
  output logic              fx2_slwr,
  output logic              fx2_pktend,
  input  logic              tx_fifo_full,
  output logic              tx_fifo_push,
  output logic [DATA_W-1:0] tx_fifo_data,
  input  logic              rx_fifo_empty,
  input  logic              rx_fifo_full,
  input  logic [DATA_W-1:0] rx_fifo_data,
  output logic              rx_fifo_pop
`ifdef FX2_ARB_STATS_EN
  ,
  output logic [31:0]       stat_rd_words,
  output logic [31:0]       stat_wr_words,
  output logic [15:0]       stat_pktends
`endif
);

  localparam int SU_W = (STARTUP_CYC > 0) ? $clog2(STARTUP_CYC + 1) : 1;
  localparam int AS_W = (ADDR_SETUP > 1) ? $clog2(ADDR_SETUP) : 1;
  localparam int BW   = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [SU_W-1:0] SU_DONE    = SU_W'(STARTUP_CYC);
  localparam logic [AS_W-1:0] ADDR_LAST  = AS_W'(ADDR_SETUP - 1);
  localparam logic [BW-1:0]   BURST_LAST = BW'(BURST_MAX - 1);

  fx2_state_e      state_r, state_s;
  fx2_side_e       last_r, grant_side_s;
  logic [SU_W-1:0] startup_cnt_r;
  logic [AS_W-1:0] addr_cnt_r;
  logic [BW-1:0]   burst_cnt_r;

  logic startup_done_s, in_req_s, out_req_s, any_req_s;
  logic rd_xfer_s, wr_xfer_s, pktend_done_s, idle_s, dirty_s, timeout_s;

  assign startup_done_s = (startup_cnt_r == SU_DONE);
  assign in_req_s       = !rx_fifo_empty;
  assign out_req_s      = fx2_flagb && !tx_fifo_full;
  assign any_req_s      = in_req_s || out_req_s || rx_fifo_full;
  assign rd_xfer_s      = (state_r == S_READ) && fx2_flagb && !tx_fifo_full;
  assign wr_xfer_s      = (state_r == S_WRITE) && fx2_flagc && !rx_fifo_empty;
  assign pktend_done_s  = (state_r == S_PKTEND) && fx2_flagc;
  assign idle_s         = (state_r == S_IDLE) && !any_req_s;

  // A full rx FIFO wins outright; otherwise contention goes to the side not served last.
  assign grant_side_s = (rx_fifo_full || (in_req_s && (!out_req_s || last_r == SIDE_OUT)))
                        ? SIDE_IN : SIDE_OUT;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!startup_done_s) begin
          state_s = S_IDLE;
        end else if (any_req_s) begin
          state_s = S_ADDR;
        end else if (timeout_s) begin
          state_s = S_PKTEND;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ADDR: begin
        if (addr_cnt_r == ADDR_LAST) begin
          state_s = (last_r == SIDE_IN) ? S_WRITE : S_READ;
        end else begin
          state_s = S_ADDR;
        end
      end
      S_READ: begin
        if (!fx2_flagb || tx_fifo_full || rx_fifo_full ||
            (rd_xfer_s && (burst_cnt_r == BURST_LAST))) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_READ;
        end
      end
      S_WRITE: begin
        if (!fx2_flagc || rx_fifo_empty || (wr_xfer_s && (burst_cnt_r == BURST_LAST))) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_WRITE;
        end
      end
      S_PKTEND: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // State, grant side and setup/burst/startup counters.
  always_ff @(posedge fx2_ifclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= S_IDLE;
      last_r        <= SIDE_OUT;
      startup_cnt_r <= '0;
      addr_cnt_r    <= '0;
      burst_cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      if ((state_r == S_IDLE) && (state_s == S_ADDR)) begin
        last_r <= grant_side_s;
      end
      if (!startup_done_s) begin
        startup_cnt_r <= startup_cnt_r + 1'b1;
      end
      addr_cnt_r <= (state_r == S_ADDR) ? addr_cnt_r + 1'b1 : '0;
      if ((state_r == S_READ) || (state_r == S_WRITE)) begin
        if (rd_xfer_s || wr_xfer_s) begin
          burst_cnt_r <= burst_cnt_r + 1'b1;
        end
      end else begin
        burst_cnt_r <= '0;
      end
    end
  end

  // Strobes follow the flags combinationally so a beat is never issued into a stalled FIFO.
  always_comb begin
    fx2_sloe     = !(state_r == S_READ);
    fx2_slrd     = !rd_xfer_s;
    tx_fifo_push = rd_xfer_s;
    fx2_slwr     = !wr_xfer_s;
    rx_fifo_pop  = wr_xfer_s;
    fx2_pktend   = !pktend_done_s;
    fx2_fd_oe    = (state_r == S_WRITE);
    tx_fifo_data = fx2_fd_i;
    if (state_r == S_WRITE) begin
      fx2_fd_o = rx_fifo_data;
    end else begin
      fx2_fd_o = '0;
    end
    if (state_r == S_PKTEND) begin
      fx2_faddr = EP6_ADDR;
    end else begin
      fx2_faddr = side_faddr(last_r);
    end
  end

  fx2_pkt_tracker #(
    .PKT_WORDS      (PKT_WORDS),
    .PKTEND_TIMEOUT (PKTEND_TIMEOUT)
  ) u_pkt_tracker (
    .fx2_ifclk   (fx2_ifclk),
    .reset_n     (reset_n),
    .wr_beat     (wr_xfer_s),
    .pktend_done (pktend_done_s),
    .idle        (idle_s),
    .dirty       (dirty_s),
    .timeout     (timeout_s)
  );

`ifdef FX2_ARB_STATS_EN
  // Wrapping event counters for push, pop and committed PKTEND.
  always_ff @(posedge fx2_ifclk or negedge reset_n) begin
    if (!reset_n) begin
      stat_rd_words <= 32'd0;
      stat_wr_words <= 32'd0;
      stat_pktends  <= 16'd0;
    end else begin
      if (rd_xfer_s) stat_rd_words <= stat_rd_words + 32'd1;
      if (wr_xfer_s) stat_wr_words <= stat_wr_words + 32'd1;
      if (pktend_done_s) stat_pktends <= stat_pktends + 16'd1;
    end
  end
`endif

endmodule
